rs232_tx_frame: RTL
===================

RS232_TX_FRAME -- requirements
Module: rs232_tx_frame

Interface
REQ-001 Parameter NBYTES, default 8: maximum bytes per frame, range 1..32.
REQ-002 Parameter NBITS, default 8: data bits per byte, range 5..9.
REQ-003 Parameter MSB_FIRST, default 1: 1 sends MSB of each byte first, 0 sends LSB first.
REQ-004 Parameter STOP_BITS, default 1: stop bits per byte, 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only with the parity macro (REQ-031).
REQ-006 Parameter DIV_W, default 16: width of baud divisor.
REQ-007 Parameter LEN_W, default $clog2(NBYTES+1): width of frame_len.
REQ-008 clk  input  1  sole clock; all logic on rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 baud_div  input  DIV_W  bit period in clk cycles.
REQ-011 frame_valid  input  1  frame_data/frame_len/baud_div are valid.
REQ-012 frame_ready  output  1  block is idle and accepts a frame.
REQ-013 frame_data  input  NBYTES*NBITS  byte k at bits [k*NBITS +: NBITS].
REQ-014 frame_len  input  LEN_W  number of bytes to send.
REQ-015 txd  output  1  registered serial line, idle high.
REQ-016 byte_start  output  1  one-cycle pulse at the first cycle of each start bit.
REQ-017 frame_done  output  1  one-cycle pulse after the last stop bit of a frame.

Function
REQ-018 The block SHALL accept a frame on a rising edge where frame_valid=1 and frame_ready=1, capturing frame_data, frame_len and baud_div into internal registers; later input changes SHALL NOT affect the frame in flight.
REQ-019 frame_ready SHALL be 1 only in IDLE and SHALL drop on the cycle after acceptance.
REQ-020 frame_len of 0 or greater than NBYTES SHALL be treated as NBYTES; captured baud_div below 2 SHALL be treated as 2.
REQ-021 Bytes SHALL be sent highest index first: byte L-1 down to byte 0, where L is the effective length.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA; DATA->PARITY (parity macro defined) or STOP after NBITS bits; PARITY->STOP; STOP->START if bytes remain, else IDLE.
REQ-023 txd SHALL go low on the first clock edge after acceptance (1-cycle latency); every start, data, parity and stop bit SHALL be held exactly baud_div cycles.
REQ-024 Consecutive bytes SHALL be sent back-to-back: the next start bit begins on the cycle after the last stop-bit cycle, with no extra idle cycles.
REQ-025 byte_start SHALL pulse for one cycle, coincident with the first low cycle of each start bit.
REQ-026 frame_done SHALL pulse for one cycle on the cycle after the final stop bit ends, coincident with frame_ready returning to 1; a new frame MAY be accepted on that same edge.
REQ-027 The baud counter SHALL be DIV_W bits wide, count 0..div-1 and clear at each bit boundary, with no wrap beyond div-1.

Reset
REQ-028 While reset=1, the block SHALL immediately force txd=1, frame_ready=0, byte_start=0, frame_done=0, state=IDLE and clear all counters, regardless of clk.
REQ-029 frame_ready SHALL be 1 on the first rising clk edge after reset deasserts.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse, and txd SHALL return high asynchronously.

Configuration
REQ-031 Macro RS232_TX_PARITY_EN: when defined, one parity bit (even or odd per PARITY_ODD, over the NBITS data bits) SHALL follow the data bits of each byte; when undefined, there SHALL be no PARITY state, no parity logic, and each byte SHALL be 1+NBITS+STOP_BITS bit periods long.

Verification
REQ-032 Defaults, macro off, baud_div=4, frame_len=1, byte0=0xA5 -> txd pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; frame_done at cycle 41 after accept.
REQ-033 Macro on, PARITY_ODD=0, MSB_FIRST=0, baud_div=3, frame_len=2, bytes {0x07,0x01} -> byte1 0x07 sent first as LSB-first data, parity 1, then byte0 0x01 with parity 1; 2 byte_start pulses 33 cycles apart.
REQ-034 frame_len=0 with NBYTES=8 -> 8 bytes sent back-to-back; frame_done after 8*10*div+1 cycles.
REQ-035 baud_div=1 -> each bit held 2 cycles; changing baud_div mid-frame has no effect on timing.
REQ-036 Reset pulsed during the 3rd data bit -> txd=1 immediately, no frame_done; frame_ready=1 on the first edge after release; a new frame is accepted and sent correctly.
REQ-037 frame_valid held high continuously -> the next frame is accepted on the frame_done cycle and its start bit begins 1 cycle later.

Source files
------------

// File: rtl/rs232_tx_frame.sv
// rs232_tx_frame: serialises a frame of up to NBYTES bytes onto an RS-232
// style line. Bytes go out highest index first, each as start bit, NBITS
// data bits, an optional parity bit and STOP_BITS stop bits, back-to-back.
//
// Optional feature: define RS232_TX_PARITY_EN to insert one parity bit
// (even, or odd when PARITY_ODD=1) after the data bits of every byte.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   baud_div            bit period in clk cycles (values below 2 act as 2)
//   frame_valid/ready   frame handshake; ready is high only while idle
//   frame_data          byte k at bits [k*NBITS +: NBITS]
//   frame_len           byte count; 0 or > NBYTES means NBYTES
//   txd                 registered serial line, idle high
//   byte_start          one-cycle pulse on the first cycle of each start bit
//   frame_done          one-cycle pulse after the last stop bit of a frame
module rs232_tx_frame #(
  parameter int unsigned NBYTES     = 8,
  parameter int unsigned NBITS      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned LEN_W      = $clog2(NBYTES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIV_W-1:0]        baud_div,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [NBYTES*NBITS-1:0] frame_data,
  input  logic [LEN_W-1:0]        frame_len,
  output logic                    txd,
  output logic                    byte_start,
  output logic                    frame_done
);

  localparam int unsigned BIT_W  = $clog2(NBITS);
  localparam int unsigned DATA_W = NBYTES * NBITS;

  // Reject out-of-range configurations at elaboration.
  if (NBYTES < 1 || NBYTES > 32 || NBITS < 5 || NBITS > 9 || MSB_FIRST > 1 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1 || DIV_W < 2) begin : g_bad_cfg
    $error("rs232_tx_frame: parameter out of range");
  end

`ifdef RS232_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state, state_n;
  logic [DIV_W-1:0]   cnt, cnt_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [BIT_W-1:0]   bit_idx, bit_n;
  logic [LEN_W-1:0]   byte_idx, byte_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic               fin_q, fin_n;

  logic               accept_c;
  logic               bit_end_c;
  logic [NBITS-1:0]   cur_byte_c;
  logic [BIT_W-1:0]   bit_sel_c;
  logic [LEN_W-1:0]   eff_len_c;
  logic               line_c;
  logic               bstart_c;
  logic               ready_c;

  assign accept_c   = frame_valid && frame_ready;
  assign bit_end_c  = (cnt == div_q - DIV_W'(1));
  assign cur_byte_c = data_q[32'(byte_idx) * NBITS +: NBITS];
  assign bit_sel_c  = (MSB_FIRST != 0) ? BIT_W'(NBITS - 1) - bit_idx : bit_idx;
  assign eff_len_c  = (frame_len == '0 || 32'(frame_len) > NBYTES) ? LEN_W'(NBYTES) : frame_len;

  // Next-state and line value; outputs are registered one cycle later, so
  // txd trails the state by one cycle and frame_done is delayed via fin_q.
  always_comb begin
    state_n  = state;
    cnt_n    = bit_end_c ? '0 : cnt + DIV_W'(1);
    div_n    = div_q;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    data_n   = data_q;
    fin_n    = 1'b0;
    line_c   = 1'b1;
    bstart_c = 1'b0;
    ready_c  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n   = '0;
        ready_c = !accept_c;
        if (accept_c) begin
          state_n = S_START;
          data_n  = frame_data;
          div_n   = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
          byte_n  = eff_len_c - LEN_W'(1);
          bit_n   = '0;
        end
      end
      S_START: begin
        line_c   = 1'b0;
        bstart_c = (cnt == '0);
        if (bit_end_c) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        line_c = cur_byte_c[bit_sel_c];
        if (bit_end_c) begin
          if (bit_idx == BIT_W'(NBITS - 1)) begin
            bit_n = '0;
`ifdef RS232_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
      end
`ifdef RS232_TX_PARITY_EN
      S_PARITY: begin
        line_c = (^cur_byte_c) ^ 1'(PARITY_ODD);
        if (bit_end_c) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_c) begin
          if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (byte_idx == '0) begin
              state_n = S_IDLE;
              fin_n   = 1'b1;
            end else begin
              state_n = S_START;
              byte_n  = byte_idx - LEN_W'(1);
            end
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div_q       <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      data_q      <= '0;
      fin_q       <= 1'b0;
      txd         <= 1'b1;
      byte_start  <= 1'b0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div_q       <= div_n;
      bit_idx     <= bit_n;
      byte_idx    <= byte_n;
      data_q      <= data_n;
      fin_q       <= fin_n;
      txd         <= line_c;
      byte_start  <= bstart_c;
      frame_done  <= fin_q;
      frame_ready <= ready_c;
    end
  end

endmodule
